// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl
// Walks a 4-input combinational block through every input vector and holds
// each vector for SETTLE+1 cycles. On the last cycle of each vector it
// records f into a truth table, counts the ones, and flags the first entry
// that differs from the table latched at start.
module kmap_sweep_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth,
    output logic [N_IN:0]        ones_cnt,
    output logic                 mismatch,
    output logic [N_IN-1:0]      fail_idx
);

    localparam int              N_VEC     = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX  = N_IN'(N_VEC - 1);
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // With no settle cycles every vector lives entirely in SAMPLE.
    localparam state_t FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t             state_reg,    state_next;
    logic [N_IN-1:0]    idx_reg,      idx_next;
    logic [3:0]         wait_reg,     wait_next;
    logic [N_VEC-1:0]   exp_reg,      exp_next;
    logic [N_VEC-1:0]   truth_reg,    truth_next;
    logic [N_IN:0]      ones_reg,     ones_next;
    logic               mismatch_reg, mismatch_next;
    logic [N_IN-1:0]    fail_reg,     fail_next;

    logic               accept;
    logic               capture;

    // A sweep begins only from IDLE; abort suppresses both start and capture.
    assign accept  = (state_reg == ST_IDLE)   && start && !abort;
    assign capture = (state_reg == ST_SAMPLE) && !abort;

    // Per-entry truth-table update: cleared on accept, written when its index is sampled.
    generate
        for (genvar gi = 0; gi < N_VEC; gi++) begin : g_truth
            assign truth_next[gi] = accept ? 1'b0 :
                                    (capture && (idx_reg == N_IN'(gi))) ? dut_out :
                                    truth_reg[gi];
        end
    endgenerate

    // Next-state and result-register update.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        wait_next     = wait_reg;
        exp_next      = exp_reg;
        ones_next     = ones_reg;
        mismatch_next = mismatch_reg;
        fail_next     = fail_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    exp_next      = expected;
                    idx_next      = '0;
                    wait_next     = SETTLE_LD;
                    ones_next     = '0;
                    mismatch_next = 1'b0;
                    fail_next     = '0;
                    state_next    = FIRST_ST;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    wait_next = wait_reg - 4'd1;
                    if (wait_reg <= 4'd1) begin
                        state_next = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    ones_next = ones_reg + {{N_IN{1'b0}}, dut_out};
                    if ((dut_out != exp_reg[idx_reg]) && !mismatch_reg) begin
                        mismatch_next = 1'b1;
                        fail_next     = idx_reg;
                    end
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        wait_next  = SETTLE_LD;
                        state_next = FIRST_ST;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            wait_reg     <= '0;
            exp_reg      <= '0;
            truth_reg    <= '0;
            ones_reg     <= '0;
            mismatch_reg <= 1'b0;
            fail_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            wait_reg     <= wait_next;
            exp_reg      <= exp_next;
            truth_reg    <= truth_next;
            ones_reg     <= ones_next;
            mismatch_reg <= mismatch_next;
            fail_reg     <= fail_next;
        end
    end

    // Outputs are pure decodes of registered state.
    assign busy     = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE);
    assign done     = (state_reg == ST_DONE);
    assign dut_in   = busy ? idx_reg : '0;
    assign truth    = truth_reg;
    assign ones_cnt = ones_reg;
    assign mismatch = mismatch_reg;
    assign fail_idx = fail_reg;

endmodule
